// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the serial BCD
// adder/subtractor.
package bcd_pkg;

    localparam int BCD_DW    = 4;
    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    // A digit is a legal BCD code when it does not exceed 9.
    function automatic logic is_bcd(input logic [BCD_DW-1:0] digit);
        return digit <= BCD_DW'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/done handshake and operand/result bus of the serial BCD adder/subtractor.
// The requester drives start/sub/a/b; the engine drives status and result.
interface bcd_serial_addsub_if #(
    parameter int NDIG = 4,
    parameter int DW   = 4
);
    logic                start;
    logic                sub;
    logic [NDIG*DW-1:0]  a;
    logic [NDIG*DW-1:0]  b;
    logic                ready;
    logic                busy;
    logic                done;
    logic [NDIG*DW-1:0]  result;
    logic                cout;
    logic                neg;
    logic                err;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, neg, err
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, neg, err
    );
endinterface

// File: rtl/bcd_serial_addsub_digit.sv
// One BCD digit of add or 10's-complement subtract. Purely combinational;
// the top level time-shares a single instance across all digits.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [BCD_DW-1:0] a_dig,
    input  logic [BCD_DW-1:0] b_dig,
    input  logic              sub,
    input  logic              cin,
    output logic [BCD_DW-1:0] dig,
    output logic              cout
);

    logic [BCD_DW-1:0] bd;
    logic [BCD_DW:0]   s;

    // Subtraction adds the 9's complement of B; the +1 arrives as the
    // initial carry. Illegal B codes simply wrap in 4 bits.
    always_comb begin
        bd   = sub ? (BCD_DW'(BCD_MAX) - b_dig) : b_dig;
        s    = {1'b0, a_dig} + {1'b0, bd} + {{BCD_DW{1'b0}}, cin};
        cout = (s >= (BCD_DW+1)'(BCD_RADIX));
        dig  = cout ? BCD_DW'(s - (BCD_DW+1)'(BCD_RADIX)) : s[BCD_DW-1:0];
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first.
// Operands are captured on start; the result register only changes on the
// final digit edge, so it holds steady until the next operation completes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; ready=1, accepts start
// RUN   | busy=1; one digit processed per cycle, idx counts digits
// DONE  | done=1 for one cycle; result valid; start accepted again
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DW   = 4
)(
    input  logic               clk,
    input  logic               rst,
    bcd_serial_addsub_if.slave bus
);

    localparam int W  = NDIG * DW;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    bcd_state_e       state_q;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     result_q;
    logic [IW-1:0]    idx_q;
    logic             sub_q;
    logic             carry_q;
    logic             cout_q;
    logic             neg_q;
    logic             err_q;

    logic [DW-1:0]    dig;
    logic             dig_cout;
    logic             last_dig;
    logic             bad_digit;
    logic [W-1:0]     acc_full;

    bcd_digit_addsub u_digit (
        .a_dig (a_sr[DW-1:0]),
        .b_dig (b_sr[DW-1:0]),
        .sub   (sub_q),
        .cin   (carry_q),
        .dig   (dig),
        .cout  (dig_cout)
    );

    assign last_dig = (idx_q == IW'(NDIG - 1));

    // Flag any non-BCD digit on either operand at capture time.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(bus.a[i*DW +: DW]) || !is_bcd(bus.b[i*DW +: DW]))
                bad_digit = 1'b1;
        end
    end

    // Partial result accumulator: new digits enter at the MSD end so that
    // after NDIG shifts digit 0 sits in the low nibble.
    generate
        if (NDIG == 1) begin : g_single
            assign acc_full = dig;
        end else begin : g_multi
            logic [W-DW-1:0] acc_q;

            // Shift the freshly computed digit into the partial accumulator.
            always_ff @(posedge clk) begin
                if (rst)
                    acc_q <= '0;
                else if (state_q == RUN)
                    acc_q <= acc_full[W-1:DW];
            end

            assign acc_full = {dig, acc_q};
        end
    endgenerate

    // FSM, operand shift registers and final result/flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            result_q <= '0;
            idx_q    <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        err_q   <= bad_digit;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> DW;
                    b_sr    <= b_sr >> DW;
                    carry_q <= dig_cout;
                    if (last_dig) begin
                        result_q <= acc_full;
                        cout_q   <= dig_cout;
                        neg_q    <= sub_q & ~dig_cout;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready  = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub with NDIG=4.
module tb_bcd_serial_addsub;

    localparam int NDIG = 4;
    localparam int W    = NDIG * 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_serial_addsub_if #(.NDIG(NDIG), .DW(4)) bus ();

    bcd_serial_addsub #(.NDIG(NDIG), .DW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         neg;
        logic         err;
        logic         chk_res;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        exp_t         e;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   last_done = 0;
    int   prev_done = 0;

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                input logic [W-1:0] r, input logic c, input logic n,
                                input logic e, input logic chk);
        vec_t v;
        v.a = a; v.b = b; v.sub = s;
        v.e.res = r; v.e.cout = c; v.e.neg = n; v.e.err = e; v.e.chk_res = chk;
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: subtraction is A + (10^N - B).
    function automatic exp_t model(input int av, input int bv, input logic s);
        exp_t e;
        int t;
        t = s ? av + (10000 - bv) : av + bv;
        e.res     = to_bcd(t % 10000);
        e.cout    = (t >= 10000);
        e.neg     = s && (t < 10000);
        e.err     = 1'b0;
        e.chk_res = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Wait for ready, present one operation for one cycle, log its expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready=%b expected 1", bus.ready);
        end
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.ready) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            tests++;
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: result=%h with no operation outstanding", bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.chk_res && (bus.result !== mon_e.res || bus.cout !== mon_e.cout ||
                     bus.neg !== mon_e.neg)) || bus.err !== mon_e.err) begin
                    fails++;
                    $display("FAIL op_result: got result=%h cout=%b neg=%b err=%b expected result=%h cout=%b neg=%b err=%b",
                             bus.result, bus.cout, bus.neg, bus.err,
                             mon_e.res, mon_e.cout, mon_e.neg, mon_e.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   nready;
        int   n;
        int   d0;
        int   av;
        int   bv;
        logic s;
        logic stable;

        vecs.push_back(mk(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h9999, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 1'b0, 1'b1));

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(bus.ready),  32'd1);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags",  {29'd0, bus.cout, bus.neg, bus.err}, 32'd0);
        rst = 1'b0;

        // Table vectors, issued as soon as ready allows (back-to-back).
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);
        drain();

        // Random valid operands against the decimal model.
        for (int i = 0; i < 16; i++) begin
            av = int'($urandom_range(0, 9999));
            bv = int'($urandom_range(0, 9999));
            s  = 1'($urandom_range(0, 1));
            issue(to_bcd(av), to_bcd(bv), s, model(av, bv, s));
        end
        drain();

        // start held high through RUN: one op, ready low for NDIG cycles.
        d0 = done_cnt;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back(mk(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1).e);
        @(negedge clk);
        nready = 0;
        n = 0;
        while (!bus.ready && n < 20) begin
            nready++;
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("held_ready_low_cycles", 32'(nready), 32'd4);
        check("held_done_latency", 32'(bus.done), 32'd1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.result !== 16'h3333 || bus.cout !== 1'b0 || bus.neg !== 1'b0) stable = 1'b0;
        end
        check("held_one_op", 32'(done_cnt - d0), 32'd1);
        check("hold_stable", 32'(stable), 32'd1);

        // Second op accepted in the DONE cycle: done spacing NDIG+1.
        issue(16'h1234, 16'h5678, 1'b0, model(1234, 5678, 1'b0));
        issue(16'h5000, 16'h1234, 1'b1, model(5000, 1234, 1'b1));
        drain();
        check("b2b_spacing", 32'(last_done - prev_done), 32'd5);

        // Reset on the second RUN cycle aborts with no done.
        @(negedge clk);
        bus.a     = 16'h9999;
        bus.b     = 16'h0001;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready",  32'(bus.ready),  32'd1);
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_cout",   32'(bus.cout),   32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset wins over a simultaneous start.
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_start_busy",  32'(bus.busy),  32'd0);
        check("rst_start_ready", 32'(bus.ready), 32'd1);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
